// File: rtl/riscv_membus_arb_pkg.sv
// Shared types for the instruction/data memory-bus arbiter.
package riscv_membus_arb_pkg;

  // Arbiter ownership of the external memory port
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IF,
    ARB_DM
  } arb_state_t;

endpackage

// File: rtl/riscv_membus_arb_if.sv
// Core-side (fetch/data) and memory-side signals of the shared memory port.
// slave: the arbiter's view; master: the surrounding core + memory environment.
interface riscv_membus_arb_if #(
  parameter int unsigned XLEN = 32
);
  // Instruction-fetch requester
  logic              if_req;
  logic [XLEN-1:0]   if_adr;
  logic              if_flush;
  logic              if_ack;
  logic [XLEN-1:0]   if_q;
  logic              if_err;
  // Data-memory requester
  logic              dm_req;
  logic [XLEN-1:0]   dm_adr;
  logic [XLEN-1:0]   dm_d;
  logic              dm_we;
  logic [XLEN/8-1:0] dm_be;
  logic              dm_ack;
  logic [XLEN-1:0]   dm_q;
  logic              dm_err;
  // External memory port
  logic              bus_req;
  logic [XLEN-1:0]   bus_adr;
  logic [XLEN-1:0]   bus_d;
  logic              bus_we;
  logic [XLEN/8-1:0] bus_be;
  logic              bus_ack;
  logic [XLEN-1:0]   bus_q;
  logic              bus_err;

  modport slave (
    input  if_req, if_adr, if_flush,
    output if_ack, if_q, if_err,
    input  dm_req, dm_adr, dm_d, dm_we, dm_be,
    output dm_ack, dm_q, dm_err,
    output bus_req, bus_adr, bus_d, bus_we, bus_be,
    input  bus_ack, bus_q, bus_err
  );

  modport master (
    output if_req, if_adr, if_flush,
    input  if_ack, if_q, if_err,
    output dm_req, dm_adr, dm_d, dm_we, dm_be,
    input  dm_ack, dm_q, dm_err,
    input  bus_req, bus_adr, bus_d, bus_we, bus_be,
    output bus_ack, bus_q, bus_err
  );

endinterface

// File: rtl/riscv_membus_arb.sv
// Shares one external memory port between instruction fetch and data memory.
// One transaction at a time, data wins ties, a starvation counter guarantees
// fetch progress, and fetch responses are discarded after a flush.
module riscv_membus_arb
  import riscv_membus_arb_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_membus_arb_if.slave    mb
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam int unsigned BEW   = XLEN / 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             drop;

  logic             bus_req_r;
  logic [XLEN-1:0]  bus_adr_r;
  logic [XLEN-1:0]  bus_d_r;
  logic             bus_we_r;
  logic [BEW-1:0]   bus_be_r;

  logic             if_want;
  logic             grant_if;
  logic             grant_dm;
  logic             if_ack_c;
  logic             dm_ack_c;

  // Grant decision, only meaningful while the port is idle
  always_comb begin
    if_want  = mb.if_req & ~mb.if_flush;
    grant_if = (state == ARB_IDLE) & if_want & (~mb.dm_req | (starve_cnt == CNT_MAX));
    grant_dm = (state == ARB_IDLE) & mb.dm_req & ~grant_if;
  end

  // Arbitration FSM: latches the winning request onto the bus and holds it until bus_ack
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      bus_req_r  <= 1'b0;
      bus_adr_r  <= '0;
      bus_d_r    <= '0;
      bus_we_r   <= 1'b0;
      bus_be_r   <= '0;
      starve_cnt <= '0;
      drop       <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          drop <= 1'b0;
          if (grant_if) begin
            state     <= ARB_IF;
            bus_req_r <= 1'b1;
            bus_adr_r <= mb.if_adr;
            bus_d_r   <= '0;
            bus_we_r  <= 1'b0;
            bus_be_r  <= '1;
          end else if (grant_dm) begin
            state     <= ARB_DM;
            bus_req_r <= 1'b1;
            bus_adr_r <= mb.dm_adr;
            bus_d_r   <= mb.dm_d;
            bus_we_r  <= mb.dm_we;
            bus_be_r  <= mb.dm_be;
          end
          // A flushed fetch neither counts as a loss nor resets the count
          if (grant_if || !mb.if_req) begin
            starve_cnt <= '0;
          end else if (grant_dm && if_want && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
          end
        end
        ARB_IF: begin
          if (mb.if_flush) begin
            drop <= 1'b1;
          end
          if (mb.bus_ack) begin
            bus_req_r <= 1'b0;
            state     <= ARB_IDLE;
          end
        end
        ARB_DM: begin
          if (mb.bus_ack) begin
            bus_req_r <= 1'b0;
            state     <= ARB_IDLE;
          end
        end
        default: begin
          state     <= ARB_IDLE;
          bus_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Completion strobes follow bus_ack combinationally, gated by ownership
  always_comb begin
    if_ack_c = mb.bus_ack & (state == ARB_IF) & ~drop & ~mb.if_flush;
    dm_ack_c = mb.bus_ack & (state == ARB_DM);
  end

  assign mb.if_ack  = if_ack_c;
  assign mb.if_q    = mb.bus_q;
  assign mb.if_err  = mb.bus_err & if_ack_c;
  assign mb.dm_ack  = dm_ack_c;
  assign mb.dm_q    = mb.bus_q;
  assign mb.dm_err  = mb.bus_err & dm_ack_c;

  assign mb.bus_req = bus_req_r;
  assign mb.bus_adr = bus_adr_r;
  assign mb.bus_d   = bus_d_r;
  assign mb.bus_we  = bus_we_r;
  assign mb.bus_be  = bus_be_r;

endmodule
